// File: rtl/turn_signal_pkg.sv
// Shared types for the tail-light sequencer: sequencing modes and step-counter sizing.
package turn_signal_pkg;

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZ} mode_t;

  function automatic int step_width(input int lamps);
    return $clog2(lamps + 1);
  endfunction

endpackage

// File: rtl/turn_signal_seq_tick_gen.sv
// Step prescaler: asserts tick for one clock every DIV clocks; DIV=1 keeps tick high.
module tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  // A one-bit counter pinned at zero covers DIV=1 without a separate generate path.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    tick    = (count_q == LAST);
    count_d = tick ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/turn_signal_seq.sv
// Parametrised tail-light sequencer: turn sweeps, hazard flash and brake overlay per side.
module turn_signal_seq
  import turn_signal_pkg::*;
#(
  parameter int LAMPS = 3,
  parameter int DIV   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               l,
  input  logic               r,
  input  logic               brake,
  output logic [2*LAMPS-1:0] y
);

  localparam int SW = step_width(LAMPS);
  localparam logic [SW-1:0] LAST = SW'(LAMPS);

  logic          tick;
  mode_t         mode_q, mode_d;
  logic [SW-1:0] step_q, step_d;
  logic          brake_q;
  logic [LAMPS-1:0] left_half, right_half;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= IDLE;
      step_q  <= '0;
      brake_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      step_q  <= step_d;
      brake_q <= brake;
    end
  end

  // Hazard request outranks everything except an active hazard step, which always drops to IDLE.
  always_comb begin
    mode_d = mode_q;
    step_d = step_q;
    if (tick) begin
      if (l && r && mode_q != HAZ) begin
        mode_d = HAZ;
        step_d = '0;
      end else begin
        case (mode_q)
          HAZ: begin
            mode_d = IDLE;
            step_d = '0;
          end
          IDLE: begin
            if (l) begin
              mode_d = LEFT;
              step_d = SW'(1);
            end else if (r) begin
              mode_d = RIGHT;
              step_d = SW'(1);
            end
          end
          default: begin
            if (step_q == LAST) begin
              mode_d = IDLE;
              step_d = '0;
            end else begin
              step_d = step_q + SW'(1);
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    left_half  = '0;
    right_half = '0;
    for (int unsigned i = 0; i < LAMPS; i++) begin
      if (mode_q == LEFT  && SW'(i) < step_q) left_half[i]              = 1'b1;
      if (mode_q == RIGHT && SW'(i) < step_q) right_half[LAMPS - 1 - i] = 1'b1;
    end
    if (mode_q == HAZ) begin
      left_half  = '1;
      right_half = '1;
    end else if (brake_q) begin
      if (mode_q != LEFT)  left_half  = '1;
      if (mode_q != RIGHT) right_half = '1;
    end
    y = {left_half, right_half};
  end

endmodule

// File: tb/tb_turn_signal_seq.sv
// Bench for turn_signal_seq: two configurations checked against a lamp-pattern reference model.
module tb_turn_signal_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       l = 1'b0, r = 1'b0, brake = 1'b0;
  logic [5:0] y0;
  logic [7:0] y1;

  int checks   = 0;
  int failures = 0;

  // Reference model state per instance: mode 0=idle 1=left 2=right 3=hazard.
  int lmp [2] = '{3, 4};
  int dv  [2] = '{1, 4};
  int m_mode [2];
  int m_step [2];
  int m_cnt  [2];
  int m_brk  [2];

  turn_signal_seq #(.LAMPS(3), .DIV(1)) u_dut0 (
    .clk(clk), .reset(reset), .l(l), .r(r), .brake(brake), .y(y0)
  );

  turn_signal_seq #(.LAMPS(4), .DIV(4)) u_dut1 (
    .clk(clk), .reset(reset), .l(l), .r(r), .brake(brake), .y(y1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_step[k] = 0; m_cnt[k] = 0; m_brk[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit t;
    for (int k = 0; k < 2; k++) begin
      m_brk[k] = brake;
      t = (m_cnt[k] == dv[k] - 1);
      m_cnt[k] = t ? 0 : m_cnt[k] + 1;
      if (t) begin
        if (l && r && m_mode[k] != 3) begin
          m_mode[k] = 3; m_step[k] = 0;
        end else if (m_mode[k] == 3) begin
          m_mode[k] = 0; m_step[k] = 0;
        end else if (m_mode[k] == 0) begin
          if (l)      begin m_mode[k] = 1; m_step[k] = 1; end
          else if (r) begin m_mode[k] = 2; m_step[k] = 1; end
        end else if (m_step[k] == lmp[k]) begin
          m_mode[k] = 0; m_step[k] = 0;
        end else begin
          m_step[k] = m_step[k] + 1;
        end
      end
    end
  endtask

  function automatic logic [7:0] model_y(input int k);
    int n, full, lh, rh;
    n    = lmp[k];
    full = (1 << n) - 1;
    lh   = 0;
    rh   = 0;
    if (m_mode[k] == 1) lh = (1 << m_step[k]) - 1;
    if (m_mode[k] == 2) rh = full & ~((1 << (n - m_step[k])) - 1);
    if (m_mode[k] == 3) begin
      lh = full; rh = full;
    end else if (m_brk[k] != 0) begin
      if (m_mode[k] != 1) lh = full;
      if (m_mode[k] != 2) rh = full;
    end
    return 8'((lh << n) | rh);
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model_l3d1", {2'b00, y0}, model_y(0));
    check("model_l4d4", y1, model_y(1));
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    model_edge();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_y0", {2'b00, y0}, 8'h00);
    check("async_rst_y1", y1, 8'h00);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0] t1 [6] = '{8'h08, 8'h18, 8'h38, 8'h00, 8'h08, 8'h18};
  logic [7:0] haz [4] = '{8'h3F, 8'h00, 8'h3F, 8'h00};
  logic [7:0] rgt [5] = '{8'h04, 8'h06, 8'h07, 8'h00, 8'h00};
  logic [7:0] brk [3] = '{8'h0F, 8'h1F, 8'h3F};

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_y0", {2'b00, y0}, 8'h00);
    check("reset_y1", y1, 8'h00);
    reset = 1'b0;

    // Left sweep from reset release, then hazard preempting mid-sweep.
    l = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("left_sweep", {2'b00, y0}, t1[i]);
    end
    r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("hazard", {2'b00, y0}, haz[i]);
    end
    l = 1'b0; r = 1'b0;
    repeat (2) cycle();

    // Right sweep with the request dropped after the first step.
    r = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("right_sweep", {2'b00, y0}, rgt[i]);
      r = 1'b0;
    end

    // Brake overlay during a left sweep, then alone.
    brake = 1'b1; l = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("brake_left", {2'b00, y0}, brk[i]);
    end
    l = 1'b0;
    repeat (2) cycle();
    brake = 1'b0;
    cycle();
    check("brake_off", {2'b00, y0}, 8'h00);
    brake = 1'b1;
    cycle();
    check("brake_on", {2'b00, y0}, 8'h3F);
    brake = 1'b0;
    cycle();

    // Mid-sequence asynchronous reset, then restart timing on both configurations.
    l = 1'b1;
    repeat (2) cycle();
    check("pre_reset_y0", {2'b00, y0}, 8'h18);
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (i == 0) check("restart_y0", {2'b00, y0}, 8'h08);
      check("restart_y1", y1, (i == 3) ? 8'h10 : 8'h00);
    end

    // Randomised input traffic with held segments so the prescaled instance sees varied requests.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        l     = ($urandom_range(0, 2) == 0);
        r     = ($urandom_range(0, 2) == 0);
        brake = ($urandom_range(0, 3) == 0);
      end
      if (i == 200) pulse_reset();
      else          cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
